bullet_scheduler: RTL and testbench

- Owns the 64-entry bullet table that the VGA renderer reads each frame as the packed 2048-bit bullet bus.
- Arbitrates fire requests from the two players, allocates free slots, and accepts slot-clear requests from collision logic.
- Once per frame, on the blanking pulse, sweeps every slot, advances each active bullet along its direction and retires bullets that leave the screen.

---
 rtl/bullet_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// Bullet table owner: arbitrates player fire requests into free slots, applies
// collision clears, and sweeps the table once per frame to move and retire bullets.
module bullet_scheduler #(
  parameter int MAX_BULLETS    = 64,
  parameter int BULLET_SIZE    = 12,
  parameter int SPEED          = 4,
  parameter int MAX_PER_PLAYER = 8,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480
) (
  input  logic                           clk,
  input  logic                           CPU_RESETN,
  input  logic                           screenEnd,
  input  logic                           p1_fire_req,
  input  logic [9:0]                     p1_fire_x,
  input  logic [8:0]                     p1_fire_y,
  input  logic [1:0]                     p1_fire_dir,
  input  logic                           p2_fire_req,
  input  logic [9:0]                     p2_fire_x,
  input  logic [8:0]                     p2_fire_y,
  input  logic [1:0]                     p2_fire_dir,
  output logic                           p1_fire_ack,
  output logic                           p2_fire_ack,
  output logic                           p1_fire_nack,
  output logic                           p2_fire_nack,
  input  logic                           clr_valid,
  input  logic [$clog2(MAX_BULLETS)-1:0] clr_idx,
  output logic [32*MAX_BULLETS-1:0]      allBulletContents,
  output logic [3:0]                     p1_count,
  output logic [3:0]                     p2_count,
  output logic                           busy
);

  localparam int IW = $clog2(MAX_BULLETS);

  typedef enum logic [1:0] {IDLE, GRANT, SWEEP} stateT;

  stateT          state, stateNext;
  logic [31:0]    slots [MAX_BULLETS];
  logic           rrPtr;     // 0 favours p1, 1 favours p2
  logic [IW-1:0]  sweepIdx;

  // Grant-side signals
  logic           req1, req2, grantP2, grantFire, grantOk, freeFound;
  logic [IW-1:0]  freeIdx;
  logic [3:0]     winnerCount;
  logic [31:0]    grantWord;

  // Sweep-side signals
  logic [9:0]     swX;
  logic [8:0]     swY;
  logic [1:0]     swDir;
  logic           swActive, swOwner, underflow, retire, sweepRetire;
  logic [10:0]    nx, ny;
  logic [31:0]    sweepWord;

  // Clear and count bookkeeping
  logic           clrActive, clrOwner, clrSame, p1Inc, p2Inc;
  logic [1:0]     p1Dec, p2Dec;

  for (genvar k = 0; k < MAX_BULLETS; k++) begin : g_pack
    assign allBulletContents[32*k +: 32] = slots[k];
  end

  assign busy = (state == SWEEP);

  function automatic logic [3:0] nextCount(input logic [3:0] c, input logic inc,
                                           input logic [1:0] dec);
    logic [4:0] t;
    t = {1'b0, c} + {4'd0, inc};
    if (t < {3'd0, dec}) t = '0;
    else                 t = t - {3'd0, dec};
    if (t > 5'(MAX_PER_PLAYER)) t = 5'(MAX_PER_PLAYER);
    return t[3:0];
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    stateNext = state;
    case (state)
      IDLE:    if (screenEnd) stateNext = SWEEP;
               else if (req1 || req2) stateNext = GRANT;
      GRANT:   stateNext = IDLE;
      SWEEP:   if (sweepIdx == IW'(MAX_BULLETS - 1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    // A request answered last cycle is still held by the player; don't serve it twice.
    req1      = p1_fire_req & ~p1_fire_ack & ~p1_fire_nack;
    req2      = p2_fire_req & ~p2_fire_ack & ~p2_fire_nack;
    grantP2   = req2 & (~req1 | rrPtr);
    grantFire = (state == GRANT) && (req1 || req2);
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slots[i][2] && !(clr_valid && clr_idx == IW'(i))) begin
        freeFound = 1'b1;
        freeIdx   = IW'(i);
      end
    end
    winnerCount = grantP2 ? p2_count : p1_count;
    grantOk     = freeFound && (winnerCount < 4'(MAX_PER_PLAYER));
    grantWord   = grantP2 ? {p2_fire_x, p2_fire_y, 8'd0, p2_fire_dir, 1'b1, 1'b1, 1'b0}
                          : {p1_fire_x, p1_fire_y, 8'd0, p1_fire_dir, 1'b1, 1'b0, 1'b0};
  end

  always_comb begin
    swX       = slots[sweepIdx][31:22];
    swY       = slots[sweepIdx][21:13];
    swDir     = slots[sweepIdx][4:3];
    swActive  = slots[sweepIdx][2];
    swOwner   = slots[sweepIdx][1];
    nx        = {1'b0, swX};
    ny        = {2'b0, swY};
    underflow = 1'b0;
    case (swDir)
      2'd0: begin underflow = swY < 9'(SPEED);  ny = {2'b0, swY} - 11'(SPEED); end
      2'd1:                                      nx = {1'b0, swX} + 11'(SPEED);
      2'd2:                                      ny = {2'b0, swY} + 11'(SPEED);
      default: begin underflow = swX < 10'(SPEED); nx = {1'b0, swX} - 11'(SPEED); end
    endcase
    retire = underflow
           | (nx + 11'(BULLET_SIZE) > 11'(SCREEN_W))
           | (ny + 11'(BULLET_SIZE) > 11'(SCREEN_H));
    sweepWord   = retire ? '0 : {nx[9:0], ny[8:0], 8'd0, swDir, 1'b1, swOwner, 1'b0};
    sweepRetire = (state == SWEEP) && swActive && retire;
  end

  always_comb begin
    clrActive = clr_valid && slots[clr_idx][2];
    clrOwner  = slots[clr_idx][1];
    clrSame   = clr_valid && (clr_idx == sweepIdx);
    p1Inc     = grantFire & grantOk & ~grantP2;
    p2Inc     = grantFire & grantOk &  grantP2;
    // A clear and a retirement of the same slot count as one removal.
    p1Dec = {1'b0, clrActive & ~clrOwner} + {1'b0, sweepRetire & ~swOwner & ~clrSame};
    p2Dec = {1'b0, clrActive &  clrOwner} + {1'b0, sweepRetire &  swOwner & ~clrSame};
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      rrPtr        <= 1'b0;
      sweepIdx     <= '0;
      p1_fire_ack  <= 1'b0;
      p2_fire_ack  <= 1'b0;
      p1_fire_nack <= 1'b0;
      p2_fire_nack <= 1'b0;
      p1_count     <= '0;
      p2_count     <= '0;
      // NOTE: the table is flop-based and must read as all zeros after reset, so every slot is reset.
      for (int k = 0; k < MAX_BULLETS; k++) slots[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so later writes in this block win cleanly.
      state        <= stateNext;
      p1_fire_ack  <= 1'b0;
      p2_fire_ack  <= 1'b0;
      p1_fire_nack <= 1'b0;
      p2_fire_nack <= 1'b0;
      p1_count     <= nextCount(p1_count, p1Inc, p1Dec);
      p2_count     <= nextCount(p2_count, p2Inc, p2Dec);

      if (state == SWEEP) begin
        sweepIdx <= sweepIdx + IW'(1);
        if (swActive) slots[sweepIdx] <= sweepWord;
      end else begin
        sweepIdx <= '0;
      end

      if (grantFire) begin
        rrPtr <= ~grantP2;
        if (grantOk) begin
          slots[freeIdx] <= grantWord;
          p1_fire_ack    <= ~grantP2;
          p2_fire_ack    <=  grantP2;
        end else begin
          p1_fire_nack   <= ~grantP2;
          p2_fire_nack   <=  grantP2;
        end
      end

      // Collision clears override any sweep or grant write to the same slot.
      if (clr_valid) slots[clr_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: ack/nack responses go through a scoreboard
// queue checked by a monitor; table, counts and busy are checked against a bench model.
module tb_bullet_scheduler;

  logic              clk = 1'b0;
  logic              CPU_RESETN = 1'b1;
  logic              screenEnd = 1'b0;
  logic              p1_fire_req = 1'b0, p2_fire_req = 1'b0;
  logic [9:0]        p1_fire_x = '0, p2_fire_x = '0;
  logic [8:0]        p1_fire_y = '0, p2_fire_y = '0;
  logic [1:0]        p1_fire_dir = '0, p2_fire_dir = '0;
  logic              p1_fire_ack, p2_fire_ack, p1_fire_nack, p2_fire_nack;
  logic              clr_valid = 1'b0;
  logic [5:0]        clr_idx = '0;
  logic [2047:0]     allBulletContents;
  logic [3:0]        p1_count, p2_count;
  logic              busy;

  bullet_scheduler dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .screenEnd(screenEnd),
    .p1_fire_req(p1_fire_req), .p1_fire_x(p1_fire_x), .p1_fire_y(p1_fire_y),
    .p1_fire_dir(p1_fire_dir),
    .p2_fire_req(p2_fire_req), .p2_fire_x(p2_fire_x), .p2_fire_y(p2_fire_y),
    .p2_fire_dir(p2_fire_dir),
    .p1_fire_ack(p1_fire_ack), .p2_fire_ack(p2_fire_ack),
    .p1_fire_nack(p1_fire_nack), .p2_fire_nack(p2_fire_nack),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .allBulletContents(allBulletContents),
    .p1_count(p1_count), .p2_count(p2_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  expQ[$];        // response code: {player2, isNack}
  logic [31:0] expSlots[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkTable(input string name);
    int bad;
    bad = -1;
    for (int k = 63; k >= 0; k--)
      if (allBulletContents[32*k +: 32] !== expSlots[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: slot %0d got %08h expected %08h", name, bad,
               allBulletContents[32*bad +: 32], expSlots[bad]);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int dir, input bit owner);
    logic [9:0] xv;
    logic [8:0] yv;
    logic [1:0] dv;
    xv = 10'(x);
    yv = 9'(y);
    dv = 2'(dir);
    return {xv, yv, 8'd0, dv, 1'b1, owner, 1'b0};
  endfunction

  task automatic popCheck(input logic [1:0] got);
    logic [1:0] exp;
    if (expQ.size() == 0) begin
      check("respExpected", 64'(expQ.size()), 64'd1);
    end else begin
      exp = expQ.pop_front();
      check("respOrder", 64'(got), 64'(exp));
    end
  endtask

  always @(negedge clk) begin
    if (CPU_RESETN) begin
      if (p1_fire_ack)  popCheck(2'b00);
      if (p1_fire_nack) popCheck(2'b01);
      if (p2_fire_ack)  popCheck(2'b10);
      if (p2_fire_nack) popCheck(2'b11);
    end
  end

  task automatic setReq(input bit p2, input bit on, input int x, input int y, input int dir);
    if (!p2) begin
      p1_fire_req = on; p1_fire_x = 10'(x); p1_fire_y = 9'(y); p1_fire_dir = 2'(dir);
    end else begin
      p2_fire_req = on; p2_fire_x = 10'(x); p2_fire_y = 9'(y); p2_fire_dir = 2'(dir);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 64; k++) expSlots[k] = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    CPU_RESETN = 1'b0;
    screenEnd = 1'b0; clr_valid = 1'b0;
    setReq(1'b0, 1'b0, 0, 0, 0);
    setReq(1'b1, 1'b0, 0, 0, 0);
    clearModel();
    repeat (2) @(negedge clk);
    CPU_RESETN = 1'b1;
    @(negedge clk);
  endtask

  // Raise one player's request and hold it until that player is answered.
  task automatic fire(input bit p2, input int x, input int y, input int dir,
                      input bit expAck, output int lat);
    expQ.push_back({p2, ~expAck});
    setReq(p2, 1'b1, x, y, dir);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (p2 ? (p2_fire_ack | p2_fire_nack) : (p1_fire_ack | p1_fire_nack)) begin
        lat = i;
        break;
      end
    end
    setReq(p2, 1'b0, x, y, dir);
    check("fireRespSeen", 64'(lat > 0), 64'd1);
  endtask

  task automatic fireBoth(input int x1, input int y1, input int d1,
                          input int x2, input int y2, input int d2,
                          input bit p2First, output int c1, output int c2);
    if (p2First) begin expQ.push_back(2'b10); expQ.push_back(2'b00); end
    else         begin expQ.push_back(2'b00); expQ.push_back(2'b10); end
    setReq(1'b0, 1'b1, x1, y1, d1);
    setReq(1'b1, 1'b1, x2, y2, d2);
    c1 = -1;
    c2 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c1 < 0 && (p1_fire_ack | p1_fire_nack)) begin c1 = cyc; p1_fire_req = 1'b0; end
      if (c2 < 0 && (p2_fire_ack | p2_fire_nack)) begin c2 = cyc; p2_fire_req = 1'b0; end
      if (c1 >= 0 && c2 >= 0) break;
    end
    p1_fire_req = 1'b0;
    p2_fire_req = 1'b0;
    check("pairBothServed", 64'(c1 >= 0 && c2 >= 0), 64'd1);
  endtask

  // One frame: pulse screenEnd, re-pulse it mid-sweep (must be ignored), count busy cycles.
  task automatic sweep(output int busyCycles);
    busyCycles = 0;
    @(negedge clk); screenEnd = 1'b1;
    @(negedge clk); screenEnd = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      busyCycles++;
      screenEnd = (i == 10);
      @(negedge clk);
    end
    screenEnd = 1'b0;
  endtask

  initial begin
    int lat, c1, c2, bc, x, ny, xl, ackCyc, fallCyc;
    bit ackInBusy;

    // Reset state
    doReset();
    checkTable("resetTable");
    check("resetCounts", {56'd0, p1_count, p2_count}, 64'd0);
    check("resetBusy", 64'(busy), 64'd0);
    check("resetAcks", {60'd0, p1_fire_ack, p1_fire_nack, p2_fire_ack, p2_fire_nack}, 64'd0);

    // Single p1 fire
    fire(1'b0, 100, 200, 1, 1'b1, lat);
    check("p1AckLatency", 64'(lat), 64'd2);
    expSlots[0] = mk(100, 200, 1, 1'b0);
    checkTable("firstFire");
    check("firstFireCount", 64'(p1_count), 64'd1);

    // Arbitration
    doReset();
    fireBoth(50, 60, 1, 70, 80, 3, 1'b0, c1, c2);
    check("pairGap", 64'(c2 - c1), 64'd2);
    expSlots[0] = mk(50, 60, 1, 1'b0);
    expSlots[1] = mk(70, 80, 3, 1'b1);
    fire(1'b0, 90, 90, 2, 1'b1, lat);
    expSlots[2] = mk(90, 90, 2, 1'b0);
    fireBoth(91, 92, 0, 71, 81, 0, 1'b1, c1, c2);
    check("pairP2FirstGap", 64'(c1 - c2), 64'd2);
    expSlots[3] = mk(71, 81, 0, 1'b1);
    expSlots[4] = mk(91, 92, 0, 1'b0);
    checkTable("arbTable");
    check("arbCounts", {56'd0, p1_count, p2_count}, {56'd0, 4'd3, 4'd2});

    // Rightward motion until the right edge retires the bullet
    doReset();
    fire(1'b0, 600, 100, 1, 1'b1, lat);
    x = 600;
    for (int f = 1; f <= 8; f++) begin
      sweep(bc);
      check("busyCycles", 64'(bc), 64'd64);
      x = x + 4;
      expSlots[0] = (x + 12 > 640) ? 32'd0 : mk(x, 100, 1, 1'b0);
      checkTable("rightMove");
      check("rightCount", 64'(p1_count), (x + 12 > 640) ? 64'd0 : 64'd1);
    end

    // Vertical and leftward edges
    doReset();
    fire(1'b0, 300, 2, 0, 1'b1, lat);
    fire(1'b1, 300, 464, 2, 1'b1, lat);
    fire(1'b0, 8, 300, 3, 1'b1, lat);
    ny = 464;
    xl = 8;
    for (int f = 1; f <= 3; f++) begin
      sweep(bc);
      ny = ny + 4;
      xl = xl - 4;
      expSlots[0] = '0;
      expSlots[1] = (ny + 12 > 480) ? 32'd0 : mk(300, ny, 2, 1'b1);
      expSlots[2] = (xl < 0) ? 32'd0 : mk(xl, 300, 3, 1'b0);
      checkTable("edgeTable");
      check("edgeP1Count", 64'(p1_count), (xl < 0) ? 64'd0 : 64'd1);
      check("edgeP2Count", 64'(p2_count), (ny + 12 > 480) ? 64'd0 : 64'd1);
    end

    // Per-player limit, nack, clears
    doReset();
    for (int i = 0; i < 8; i++) begin
      fire(1'b0, 10 * i + 10, 50, 1, 1'b1, lat);
      expSlots[i] = mk(10 * i + 10, 50, 1, 1'b0);
    end
    check("limitCount", 64'(p1_count), 64'd8);
    fire(1'b0, 500, 50, 1, 1'b0, lat);
    checkTable("nackNoChange");
    check("nackCount", 64'(p1_count), 64'd8);
    @(negedge clk); clr_valid = 1'b1; clr_idx = 6'd3;
    @(negedge clk); clr_valid = 1'b0;
    expSlots[3] = '0;
    checkTable("clearSlot");
    check("clearCount", 64'(p1_count), 64'd7);
    clr_valid = 1'b1; clr_idx = 6'd20;
    @(negedge clk); clr_valid = 1'b0;
    check("clearInactiveCount", 64'(p1_count), 64'd7);
    fire(1'b0, 111, 111, 2, 1'b1, lat);
    expSlots[3] = mk(111, 111, 2, 1'b0);
    checkTable("refillLowest");
    check("refillCount", 64'(p1_count), 64'd8);

    // Request raised during a sweep waits for the sweep to finish
    doReset();
    fire(1'b0, 100, 100, 1, 1'b1, lat);
    expQ.push_back(2'b10);
    @(negedge clk); screenEnd = 1'b1;
    @(negedge clk); screenEnd = 1'b0;
    ackInBusy = 1'b0;
    ackCyc = -1;
    fallCyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (i == 5) setReq(1'b1, 1'b1, 200, 200, 0);
      if (busy && (p2_fire_ack | p2_fire_nack)) ackInBusy = 1'b1;
      if (!busy && fallCyc < 0) fallCyc = cyc;
      if (p2_fire_ack | p2_fire_nack) begin ackCyc = cyc; break; end
      @(negedge clk);
    end
    setReq(1'b1, 1'b0, 0, 0, 0);
    check("noAckWhileBusy", 64'(ackInBusy), 64'd0);
    check("ackAfterSweep", 64'(ackCyc - fallCyc), 64'd2);
    expSlots[0] = mk(104, 100, 1, 1'b0);
    expSlots[1] = mk(200, 200, 0, 1'b1);
    checkTable("midSweepFire");

    // Reset in the middle of a sweep
    @(negedge clk); screenEnd = 1'b1;
    @(negedge clk); screenEnd = 1'b0;
    repeat (30) @(negedge clk);
    check("busyBeforeReset", 64'(busy), 64'd1);
    CPU_RESETN = 1'b0;
    #1;
    clearModel();
    check("resetMidSweepBusy", 64'(busy), 64'd0);
    checkTable("resetMidSweepTable");
    check("resetMidSweepCounts", {56'd0, p1_count, p2_count}, 64'd0);
    repeat (2) @(negedge clk);
    CPU_RESETN = 1'b1;
    @(negedge clk);
    fire(1'b0, 20, 30, 2, 1'b1, lat);
    expSlots[0] = mk(20, 30, 2, 1'b0);
    checkTable("afterResetFire");

    repeat (3) @(negedge clk);
    check("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
